// File: rtl/jellyvl_etherneco_pkg.sv
// Shared types and defaults for the EtherNeco slave receive/transmit datapath.
package jellyvl_etherneco_pkg;

   localparam int DEFAULT_COUNT_WIDTH  = 16;
   localparam int DEFAULT_HEADER_BYTES = 8;

   typedef logic [DEFAULT_COUNT_WIDTH-1:0] t_count;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } t_state;

endpackage

// File: rtl/jellyvl_etherneco_slot_alu.sv
// Per-byte slot rewrite: masked replace, or one byte of a little-endian add with carry.
module jellyvl_etherneco_slot_alu (
   input  logic [7:0] s_data,
   input  logic [7:0] slot_byte,
   input  logic       mask,
   input  logic       add,
   input  logic       carry_in,
   output logic [7:0] out_data,
   output logic       carry_out
);

   logic [8:0] sum;

   always_comb begin
      sum       = {1'b0, s_data} + {1'b0, slot_byte} + {8'd0, carry_in};
      out_data  = mask ? slot_byte : s_data;
      carry_out = 1'b0;
      if (add) begin
         out_data  = sum[7:0];
         carry_out = sum[8];
      end
   end

endmodule

// File: rtl/jellyvl_etherneco_slave_slot_writer.sv
// Forwards a byte stream with one cycle of latency, rewriting and capturing this node's slot.
module jellyvl_etherneco_slave_slot_writer
   import jellyvl_etherneco_pkg::*;
#(
   parameter int SLOT_BYTES   = 4,
   parameter int HEADER_BYTES = DEFAULT_HEADER_BYTES,
   parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH,
   parameter int NODE_WIDTH   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NODE_WIDTH-1:0]   node_id,
   input  logic [SLOT_BYTES*8-1:0] slot_data,
   input  logic [SLOT_BYTES-1:0]   slot_mask,
   input  logic                    slot_add,
   input  logic                    rx_start,
   input  logic                    rx_error,
   input  logic                    rx_end,
   input  logic                    s_first,
   input  logic                    s_last,
   input  logic                    s_valid,
   input  logic [7:0]              s_data,
   output logic                    m_first,
   output logic                    m_last,
   output logic                    m_valid,
   output logic [7:0]              m_data,
   output logic [SLOT_BYTES*8-1:0] cap_data,
   output logic                    cap_valid,
   output logic                    short_error
);

   localparam int DATA_W = SLOT_BYTES * 8;
   localparam int KW     = (SLOT_BYTES > 1) ? $clog2(SLOT_BYTES) : 1;
   localparam logic [COUNT_WIDTH-1:0] SLOT_C = COUNT_WIDTH'(SLOT_BYTES);
   localparam logic [COUNT_WIDTH-1:0] HDR_C  = COUNT_WIDTH'(HEADER_BYTES);
   localparam logic [COUNT_WIDTH-1:0] LAST_K = COUNT_WIDTH'(SLOT_BYTES - 1);

   t_state                 state, state_next;
   logic [COUNT_WIDTH-1:0] count, count_next;
   logic                   carry, carry_next;
   logic                   slot_open, slot_open_next;
   logic [DATA_W-1:0]      shadow, shadow_next;
   logic [DATA_W-1:0]      cap_next;
   logic                   cap_valid_next, short_error_next, m_valid_next;
   logic [7:0]             m_data_next;

   logic [NODE_WIDTH-1:0]  cfg_node;
   logic [DATA_W-1:0]      cfg_data;
   logic [SLOT_BYTES-1:0]  cfg_mask;
   logic                   cfg_add;

   logic                   frame_evt, start, beat, in_slot;
   logic [NODE_WIDTH-1:0]  cur_node;
   logic [DATA_W-1:0]      cur_data;
   logic [SLOT_BYTES-1:0]  cur_mask;
   logic                   cur_add;
   logic [COUNT_WIDTH-1:0] idx, pos, k;
   logic [KW-1:0]          k_idx;
   logic [7:0]             alu_out;
   logic                   alu_carry;

   // Framing events win over any beat presented in the same cycle.
   assign frame_evt = rx_start | rx_end | rx_error;
   assign start     = (state == IDLE) && s_valid && s_first;
   assign beat      = !frame_evt && s_valid && (start || (state == BUSY));

   // The s_first beat uses the live configuration; later beats use the latched copy.
   assign cur_node = start ? node_id   : cfg_node;
   assign cur_data = start ? slot_data : cfg_data;
   assign cur_mask = start ? slot_mask : cfg_mask;
   assign cur_add  = start ? slot_add  : cfg_add;

   assign idx     = start ? '0 : count;
   assign pos     = HDR_C + COUNT_WIDTH'(cur_node) * SLOT_C;
   assign k       = idx - pos;
   assign k_idx   = k[KW-1:0];
   assign in_slot = beat && (idx >= pos) && (k < SLOT_C);

   jellyvl_etherneco_slot_alu u_alu (
      .s_data    (s_data),
      .slot_byte (cur_data[8*k_idx +: 8]),
      .mask      (cur_mask[k_idx]),
      .add       (cur_add),
      .carry_in  ((k == '0) ? 1'b0 : carry),
      .out_data  (alu_out),
      .carry_out (alu_carry)
   );

   always_comb begin
      state_next       = state;
      count_next       = count;
      carry_next       = carry;
      slot_open_next   = slot_open;
      shadow_next      = shadow;
      cap_next         = cap_data;
      cap_valid_next   = 1'b0;
      short_error_next = 1'b0;
      m_valid_next     = 1'b0;
      m_data_next      = s_data;

      if (beat) begin
         m_valid_next = 1'b1;
         state_next   = BUSY;
         count_next   = (idx == '1) ? idx : idx + COUNT_WIDTH'(1);
         if (start) begin
            slot_open_next = 1'b0;
         end
         if (in_slot) begin
            m_data_next                = alu_out;
            carry_next                 = alu_carry;
            shadow_next[8*k_idx +: 8]  = s_data;
            if (k == LAST_K) begin
               cap_next       = shadow_next;
               cap_valid_next = 1'b1;
               slot_open_next = 1'b0;
            end else begin
               slot_open_next = 1'b1;
            end
         end
         if (s_last) begin
            state_next       = IDLE;
            short_error_next = slot_open_next;
         end
      end else if (frame_evt) begin
         state_next = IDLE;
      end
   end

   // Stage boundary: stream and slot state registered; data registers carry no reset.
   always_ff @(posedge clk) begin
      m_first <= s_first;
      m_last  <= s_last;
      m_data  <= m_data_next;
      shadow  <= shadow_next;
      if (beat && start) begin
         cfg_node <= node_id;
         cfg_data <= slot_data;
         cfg_mask <= slot_mask;
         cfg_add  <= slot_add;
      end

      if (reset || rx_error) begin
         state       <= IDLE;
         count       <= '0;
         carry       <= 1'b0;
         slot_open   <= 1'b0;
         cap_data    <= '0;
         cap_valid   <= 1'b0;
         short_error <= 1'b0;
         m_valid     <= 1'b0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         carry       <= carry_next;
         slot_open   <= slot_open_next;
         cap_data    <= cap_next;
         cap_valid   <= cap_valid_next;
         short_error <= short_error_next;
         m_valid     <= m_valid_next;
      end
   end

endmodule

// File: tb/tb_jellyvl_etherneco_slave_slot_writer.sv
// Bench for the slot writer: table rows, framing corner cases and random packets vs a packet-level model.
module tb_jellyvl_etherneco_slave_slot_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  node_id;
   logic [31:0] slot_data;
   logic [3:0]  slot_mask;
   logic        slot_add;
   logic        rx_start, rx_error, rx_end;
   logic        s_first, s_last, s_valid;
   logic [7:0]  s_data;
   logic        m_first, m_last, m_valid;
   logic [7:0]  m_data;
   logic [31:0] cap_data;
   logic        cap_valid, short_error;
   logic        h0_m_first, h0_m_last, h0_m_valid;
   logic [7:0]  h0_m_data;
   logic [31:0] h0_cap_data;
   logic        h0_cap_valid, h0_short_error;

   always #5 clk = ~clk;

   jellyvl_etherneco_slave_slot_writer dut (
      .clk(clk), .reset(reset), .node_id(node_id), .slot_data(slot_data),
      .slot_mask(slot_mask), .slot_add(slot_add), .rx_start(rx_start),
      .rx_error(rx_error), .rx_end(rx_end), .s_first(s_first), .s_last(s_last),
      .s_valid(s_valid), .s_data(s_data), .m_first(m_first), .m_last(m_last),
      .m_valid(m_valid), .m_data(m_data), .cap_data(cap_data),
      .cap_valid(cap_valid), .short_error(short_error)
   );

   jellyvl_etherneco_slave_slot_writer #(.HEADER_BYTES(0)) dut_h0 (
      .clk(clk), .reset(reset), .node_id(node_id), .slot_data(slot_data),
      .slot_mask(slot_mask), .slot_add(slot_add), .rx_start(rx_start),
      .rx_error(rx_error), .rx_end(rx_end), .s_first(s_first), .s_last(s_last),
      .s_valid(s_valid), .s_data(s_data), .m_first(h0_m_first), .m_last(h0_m_last),
      .m_valid(h0_m_valid), .m_data(h0_m_data), .cap_data(h0_cap_data),
      .cap_valid(h0_cap_valid), .short_error(h0_short_error)
   );

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   logic [7:0]  pkt[$];
   logic [7:0]  oq_d[$], oh_d[$];
   logic        oq_f[$], oq_l[$], oh_f[$];
   int          oq_c[$], in_c[$];
   int          cap_cnt, cap_idx, short_cnt, h0_cap_cnt;
   logic [31:0] cap_seen, exp_cap_data;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (m_valid) begin
         oq_d.push_back(m_data);
         oq_f.push_back(m_first);
         oq_l.push_back(m_last);
         oq_c.push_back(cyc);
      end
      if (cap_valid) begin
         cap_cnt++;
         cap_idx  = oq_d.size() - 1;
         cap_seen = cap_data;
      end
      if (short_error) short_cnt++;
      if (h0_m_valid) begin
         oh_d.push_back(h0_m_data);
         oh_f.push_back(h0_m_first);
      end
      if (h0_cap_valid) h0_cap_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      oq_d.delete(); oq_f.delete(); oq_l.delete(); oq_c.delete(); in_c.delete();
      oh_d.delete(); oh_f.delete();
      cap_cnt = 0; short_cnt = 0; h0_cap_cnt = 0; cap_idx = -1;
   endtask

   task automatic idle_inputs();
      s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
      rx_start = 1'b0; rx_end = 1'b0; rx_error = 1'b0;
   endtask

   // Drives pkt[] as one packet and checks it against the slot rules for HEADER_BYTES=8, SLOT_BYTES=4.
   task automatic run_packet(input int node, input logic [31:0] sdata, input logic [3:0] mask,
                             input bit add, input bit gaps, input int extra_first,
                             input bit jitter, input int drops);
      int          len, pos, present;
      logic [31:0] orig, mexp, res;
      logic [7:0]  exp_b;
      len = pkt.size();
      @(negedge clk);
      clear_mon();
      for (int d = 0; d < drops; d++) begin
         s_valid = 1'b1; s_first = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
         @(negedge clk);
      end
      for (int i = 0; i < len; i++) begin
         s_valid = 1'b1;
         s_first = (i == 0) || (i == extra_first);
         s_last  = (i == len - 1);
         s_data  = pkt[i];
         if (i == 0) begin
            node_id = 8'(node); slot_data = sdata; slot_mask = mask; slot_add = add;
         end else if (jitter) begin
            node_id = 8'($urandom_range(0, 7)); slot_data = $urandom;
            slot_mask = 4'($urandom); slot_add = 1'($urandom);
         end
         in_c.push_back(cyc);
         @(negedge clk);
         if (gaps && $urandom_range(0, 2) == 0) begin
            s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
      repeat (3) @(negedge clk);

      pos = 8 + node * 4;
      orig = '0; present = 0;
      for (int k = 0; k < 4; k++)
         if (pos + k < len) begin
            orig[8*k +: 8] = pkt[pos + k];
            present++;
         end
      for (int k = 0; k < 4; k++) mexp[8*k +: 8] = {8{mask[k]}};
      res = add ? orig + sdata : (orig & ~mexp) | (sdata & mexp);

      chk("out_len", oq_d.size(), len);
      for (int i = 0; i < len; i++) begin
         exp_b = pkt[i];
         if (i >= pos && i < pos + present) exp_b = res[8*(i - pos) +: 8];
         chk("m_data", oq_d[i], exp_b);
         chk("m_first", oq_f[i], (i == 0) || (i == extra_first));
         chk("m_last", oq_l[i], i == len - 1);
         chk("latency", oq_c[i] - in_c[i], 1);
      end
      chk("cap_valid_cnt", cap_cnt, (present == 4) ? 1 : 0);
      if (present == 4) begin
         chk("cap_seen", cap_seen, orig);
         chk("cap_index", cap_idx, pos + 3);
         exp_cap_data = orig;
      end
      chk("short_cnt", short_cnt, (present > 0 && present < 4) ? 1 : 0);
      chk("cap_data_hold", cap_data, exp_cap_data);
   endtask

   typedef struct {
      int          node;
      logic [31:0] sdata;
      logic [3:0]  mask;
      bit          add;
      int          len;
      logic [31:0] slot_in;
      bit          gaps;
      int          extra_first;
      logic [31:0] exp_out;
      logic [3:0]  exp_present;
      bit          exp_cap;
      bit          exp_short;
   } vec_t;

   vec_t tbl[9];

   task automatic build_pkt(input int len, input int pos, input logic [31:0] slot_in);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'(i * 13 + 5));
      for (int k = 0; k < 4; k++)
         if (pos + k < len) pkt[pos + k] = slot_in[8*k +: 8];
   endtask

   initial begin
      int pos, len;
      logic [31:0] h0_orig;

      tbl[0] = '{2, 32'h11223344, 4'hF, 0, 24, 32'hD3C2B1A0, 0, -1, 32'h11223344, 4'hF, 1, 0};
      tbl[1] = '{2, 32'h11223344, 4'h5, 0, 24, 32'hD3C2B1A0, 0, -1, 32'hD322B144, 4'hF, 1, 0};
      tbl[2] = '{2, 32'h00000001, 4'h0, 1, 24, 32'h0000FFFF, 1, -1, 32'h00010000, 4'hF, 1, 0};
      tbl[3] = '{3, 32'h0F0F0F0F, 4'hA, 1, 30, 32'h12345678, 1, -1, 32'h21436587, 4'hF, 1, 0};
      tbl[4] = '{2, 32'h11223344, 4'hF, 0, 18, 32'hD3C2B1A0, 0, -1, 32'h00003344, 4'h3, 0, 1};
      tbl[5] = '{2, 32'h11223344, 4'hF, 0, 10, 32'hD3C2B1A0, 0, -1, 32'h00000000, 4'h0, 0, 0};
      tbl[6] = '{0, 32'h00000001, 4'hF, 1, 12, 32'hFFFFFFFF, 1, -1, 32'h00000000, 4'hF, 1, 0};
      tbl[7] = '{5, 32'hAABBCCDD, 4'h8, 0, 40, 32'h44332211, 0, 20, 32'hAA332211, 4'hF, 1, 0};
      tbl[8] = '{1, 32'h00000102, 4'h0, 1, 14, 32'h0000FFFF, 1, -1, 32'h00000101, 4'h3, 0, 1};

      idle_inputs();
      node_id = '0; slot_data = '0; slot_mask = '0; slot_add = 1'b0; s_data = '0;
      exp_cap_data = '0;
      clear_mon();

      // Reset with traffic present: nothing may come out.
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         s_valid = 1'b1; s_first = 1'b1; s_data = 8'($urandom);
      end
      @(negedge clk);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_cap_valid", cap_valid, 1'b0);
      chk("rst_short_error", short_error, 1'b0);
      chk("rst_cap_data", cap_data, 32'h0);
      idle_inputs();
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int r = 0; r < 9; r++) begin
         pos = 8 + tbl[r].node * 4;
         build_pkt(tbl[r].len, pos, tbl[r].slot_in);
         run_packet(tbl[r].node, tbl[r].sdata, tbl[r].mask, tbl[r].add, tbl[r].gaps,
                    tbl[r].extra_first, 1'b1, r % 3);
         for (int k = 0; k < 4; k++)
            if (tbl[r].exp_present[k]) chk("tbl_slot_byte", oq_d[pos + k], tbl[r].exp_out[8*k +: 8]);
         chk("tbl_cap", cap_cnt, tbl[r].exp_cap);
         chk("tbl_short", short_cnt, tbl[r].exp_short);
         if (tbl[r].exp_cap) chk("tbl_cap_data", cap_data, tbl[r].slot_in);
      end

      // rx_error on slot byte 1 of an add-mode packet (byte 16 = FF+01 leaves carry set).
      @(negedge clk);
      clear_mon();
      node_id = 8'd2; slot_data = 32'h00000001; slot_mask = 4'h0; slot_add = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1; s_first = (i == 0); s_last = (i == 19);
         s_data = (i == 16) ? 8'hFF : 8'(i);
         rx_error = (i == 17);
         @(negedge clk);
         if (i == 17) chk("rxerr_m_valid_next", m_valid, 1'b0);
      end
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rxerr_out_len", oq_d.size(), 17);
      chk("rxerr_slot0", oq_d[16], 8'h00);
      chk("rxerr_cap_cnt", cap_cnt, 0);
      chk("rxerr_short_cnt", short_cnt, 0);
      chk("rxerr_cap_cleared", cap_data, 32'h0);
      exp_cap_data = '0;
      build_pkt(24, 16, 32'h00000000);
      run_packet(2, 32'h00000005, 4'h0, 1'b1, 1'b0, -1, 1'b0, 0);
      chk("rxerr_after_slot0", oq_d[16], 8'h05);

      // rx_start alongside s_first wins: the whole packet is dropped.
      @(negedge clk);
      clear_mon();
      node_id = 8'd0;
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1; s_first = (i == 0); s_last = (i == 5); s_data = 8'(i);
         rx_start = (i == 0);
         @(negedge clk);
      end
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rxstart_dropped", oq_d.size(), 0);

      // rx_end mid-packet: three bytes forwarded, remainder dropped, capture kept.
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1; s_first = (i == 0); s_last = (i == 7); s_data = 8'(i + 100);
         rx_end = (i == 3);
         @(negedge clk);
      end
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rxend_out_len", oq_d.size(), 3);
      chk("rxend_cap_kept", cap_data, exp_cap_data);

      // Zero header, node 0: slot begins on the s_first byte.
      build_pkt(10, 8, 32'h00000000);
      h0_orig = {pkt[3], pkt[2], pkt[1], pkt[0]};
      run_packet(0, 32'hA1B2C3D4, 4'hF, 1'b0, 1'b0, -1, 1'b0, 0);
      chk("h0_byte0", oh_d[0], 8'hD4);
      chk("h0_first", oh_f[0], 1'b1);
      chk("h0_byte3", oh_d[3], 8'hA1);
      chk("h0_byte4", oh_d[4], pkt[4]);
      chk("h0_cap_cnt", h0_cap_cnt, 1);
      chk("h0_cap_data", h0_cap_data, h0_orig);

      // Random packets checked by the packet-level model inside run_packet.
      for (int n = 0; n < 150; n++) begin
         len = $urandom_range(2, 48);
         pkt.delete();
         for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
         run_packet($urandom_range(0, 7), $urandom, 4'($urandom), 1'($urandom),
                    1'($urandom), ($urandom_range(0, 4) == 0) ? $urandom_range(1, len - 1) : -1,
                    1'($urandom), $urandom_range(0, 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
